// File: rtl/usr_pkg.sv
// Shared codes for the universal shift register: direct modes, burst ops, burst FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101
  } mode_e;

  typedef enum logic [1:0] {
    BOP_SHL  = 2'b00,
    BOP_SHR  = 2'b01,
    BOP_ROTL = 2'b10,
    BOP_ROTR = 2'b11
  } bop_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bursts reuse the direct-mode datapath, so map each burst op onto its direct mode.
  function automatic mode_e bop2mode(input bop_e b);
    case (b)
      BOP_SHL:  return MODE_SHL;
      BOP_SHR:  return MODE_SHR;
      BOP_ROTL: return MODE_ROTL;
      default:  return MODE_ROTR;
    endcase
  endfunction

endpackage

// File: rtl/usr_next.sv
// Next-value generator for the shift register; purely combinational, no flow control.
// Rotate ops exist only when ROTATE_EN is defined, otherwise they fall through to hold.
module usr_next
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       op,
  input  logic             ser_lo,
  input  logic             ser_hi,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      MODE_LOAD: q_next = din;
      MODE_SHL:  q_next = {q[WIDTH-2:0], ser_lo};
      MODE_SHR:  q_next = {ser_hi, q[WIDTH-1:1]};
`ifdef ROTATE_EN
      MODE_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROTR: q_next = {q[0], q[WIDTH-1:1]};
`endif
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with counted burst shifting; direct ops land in q one edge later,
// bursts hold busy for min(cnt,WIDTH)+1 edges and ignore mode/din/start meanwhile (ROTATE_EN enables rotates).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             ser_lo,
  input  logic             ser_hi,
  input  logic             start,
  input  logic [1:0]       bop,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout_hi,
  output logic             sout_lo,
  output logic             busy,
  output logic             done
);

  state_e           state;
  bop_e             bop_r;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] cnt_sat;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] q_next;
  logic             bop_ok;

`ifdef ROTATE_EN
  assign bop_ok = 1'b1;
`else
  // Rotate bursts are refused outright so they never raise busy.
  assign bop_ok = ~bop[1];
`endif

  assign cnt_sat = (cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cnt;
  assign op_sel  = (state == RUN) ? bop2mode(bop_r) : mode;

  usr_next #(.WIDTH(WIDTH)) u_next (
    .q      (q),
    .din    (din),
    .op     (op_sel),
    .ser_lo (ser_lo),
    .ser_hi (ser_hi),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bop_r <= BOP_SHL;
      rem   <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && bop_ok) begin
            state <= RUN;
            rem   <= cnt_sat;
            bop_r <= bop_e'(bop);
          end else begin
            q <= q_next;
          end
        end
        default: begin
          if (rem != '0) begin
            q   <= q_next;
            rem <= rem - CNT_W'(1);
          end
          // Last shift (or an empty burst) closes the run on this same edge.
          if (rem <= CNT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign sout_hi = q[WIDTH-1];
  assign sout_lo = q[0];

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: hold, parallel load, shift up/down and optional rotate, plus a counted burst mode that shifts a programmed number of positions autonomously with a busy/done handshake. It is the general-purpose storage/serialiser element in the lab datapath. It replaces fixed 4-bit shift/load registers and serves as the serial-to-parallel and parallel-to-serial stage for wider words.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), burst count width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  3  direct operation code (see Operation)
- din  in  WIDTH  parallel load data
- ser_lo  in  1  serial fill bit entering bit 0 on shift-up
- ser_hi  in  1  serial fill bit entering bit WIDTH-1 on shift-down
- start  in  1  burst request, sampled on clk
- bop  in  2  burst operation: 00 shl, 01 shr, 10 rotl, 11 rotr
- cnt  in  CNT_W  burst shift count
- q  out  WIDTH  register contents
- sout_hi  out  1  q[WIDTH-1], combinational from q
- sout_lo  out  1  q[0], combinational from q
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Reset: q=0, busy=0, done=0, internal remaining-count=0; takes effect immediately, including mid-burst.
- Direct modes (applied only when busy=0 and no burst is accepted this edge): 000 hold; 001 load q<=din; 010 shl q<={q[W-2:0],ser_lo}; 011 shr q<={ser_hi,q[W-1:1]}; 100 rotl q<={q[W-2:0],q[W-1]}; 101 rotr q<={q[0],q[W-1:1]}; 110/111 hold.
- Burst accept: start=1 while busy=0 with legal bop → busy<=1, rem<=min(cnt,WIDTH), latch bop. No shift on the accepting edge. start has priority over mode.
- Busy edges: if rem≠0, apply latched bop once (shl/shr use live ser_lo/ser_hi each cycle); rem<=rem-1. If rem≤1: busy<=0, done<=1.
- done is high exactly one cycle; otherwise 0.
- While busy: mode, din and start are ignored.
- cnt=0: burst completes one edge after accept, q unchanged.
- cnt>WIDTH: saturated to WIDTH.

## Timing
- Direct modes: result visible in q one edge after sampling.
- Burst with n≥1: accept at edge E0; shifts at E1..En; busy high E0..En (falls at En); done high for the cycle after En.
- Back-to-back: a new start is accepted on the edge where done is high, i.e. when busy=0.
- sout_hi/sout_lo: zero-latency from q. No combinational path from inputs to outputs.

## Configuration
- ROTATE_EN defined: modes 100/101 and bop 10/11 rotate as specified.
- ROTATE_EN undefined: modes 100/101 behave as hold. start with bop 10/11 is ignored: no busy, no done, q unchanged. Rotate logic is absent from the netlist.

## Structure
- Package usr_pkg: mode codes (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROTL, MODE_ROTR), burst codes (BOP_SHL, BOP_SHR, BOP_ROTL, BOP_ROTR), 2-state burst FSM enum (IDLE, RUN).
- Sub-module usr_next: combinational next-value generator (q, op, ser_lo, ser_hi → q_next), shared by the direct and burst paths.
- Top-level: state register, rem counter, FSM, done pulse.

## Test plan
All scenarios use WIDTH=8.
- Reset: rst_n=0 with arbitrary inputs → q=0x00, busy=0, done=0. Release, mode=000 → q stays 0x00.
- Load 0xA5, then mode=010 with ser_lo=1 → q=0x4B. Reload 0xA5, mode=011 with ser_hi=0 → q=0x52.
- q=0x81, start with bop=00, cnt=3, ser_lo=0 → busy for 4 cycles; q steps 0x02, 0x04, 0x08; done high 1 cycle. mode=001 asserted during busy has no effect.
- Boundaries: cnt=0 → done one edge after accept, q unchanged. cnt=12 from 0xFF with ser_lo=0 → exactly 8 shifts, q=0x00.
- ROTATE_EN defined: q=0x01, mode=101 → 0x80; burst bop=10, cnt=8 from 0x3C → 0x3C. ROTATE_EN undefined: mode=101 holds; start with bop=10 → busy stays 0.
- rst_n pulsed low at E2 of a cnt=5 burst → q=0x00 and busy=0 immediately; done never asserts; the next start is accepted normally.
